// File: rtl/seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// | Module : seg_scan_pkg                                                   |
// | Shared state encoding, segment table and decoder enables for the scan. |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  typedef struct packed {
    logic e1;
    logic e2;
    logic e3;
  } dec_en_t;

  localparam dec_en_t c_DEC_ON  = '{e1: 1'b1, e2: 1'b0, e3: 1'b0};
  localparam dec_en_t c_DEC_OFF = '{e1: 1'b0, e2: 1'b1, e3: 1'b1};

  localparam logic [7:0] c_SEG_DARK  = 8'hFF;
  localparam logic [6:0] c_SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] c_HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Index of the most significant nonzero nibble; 0 when the word is zero.
  function automatic logic [2:0] msd_index(input logic [31:0] word);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (word[4*i +: 4] != 4'd0) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// | Module : seg_scan_ctrl_if                                               |
// | Load handshake and display-drive bundle of the scan controller.         |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

interface seg_scan_ctrl_if;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        load_valid;
  logic        load_ready;
  logic        scan_en;
  logic        sel_a;
  logic        sel_b;
  logic        sel_c;
  logic        dec_e1;
  logic        dec_e2;
  logic        dec_e3;
  logic [7:0]  seg_n;
  logic        frame_done;

  modport master (
    output data_in, dp_in, load_valid, scan_en,
    input  load_ready, sel_a, sel_b, sel_c, dec_e1, dec_e2, dec_e3,
           seg_n, frame_done
  );

  modport slave (
    input  data_in, dp_in, load_valid, scan_en,
    output load_ready, sel_a, sel_b, sel_c, dec_e1, dec_e2, dec_e3,
           seg_n, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/hex7seg.sv
// ---------------------------------------------------------------------------
// | Module : hex7seg                                                        |
// | Combinational nibble to active-low 7-segment pattern.                   |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module hex7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = c_HEX_SEG[nibble_i];

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// | Module : seg_scan_ctrl                                                  |
// | 8-digit multiplexed 7-segment scanner with double-buffered load.        |
// | Option : LZ_BLANK_EN enables leading-zero blanking.                     |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.slave  bus
);

  localparam int c_CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX);
  localparam logic [c_CNT_W-1:0] c_SHOW_LOAD  = c_CNT_W'(SCAN_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_BLANK_LOAD = c_CNT_W'(BLANK_CYC - 1);

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]          disp_data_q, disp_data_d;
  logic [7:0]           disp_dp_q, disp_dp_d;
  logic [31:0]          pend_data_q, pend_data_d;
  logic [7:0]           pend_dp_q, pend_dp_d;
  logic                 pend_full_q, pend_full_d;
  logic                 ready_q, ready_d;
  logic [2:0]           sel_q, sel_d;
  dec_en_t              dec_q, dec_d;
  logic [7:0]           seg_q, seg_d;
  logic                 frame_done_q, frame_done_d;

  logic                 w_accept;
  logic                 w_wrap;
  logic [3:0]           w_nibble;
  logic [6:0]           w_seg7;
  logic                 w_lz_blank;

  assign w_accept = bus.load_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    w_wrap      = 1'b0;

    if (!bus.scan_en) begin
      state_d = ST_IDLE;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          idx_d   = 3'd0;
          cnt_d   = c_SHOW_LOAD;
        end
        ST_SHOW: begin
          if (cnt_q == '0) begin
            state_d = ST_BLANK;
            cnt_d   = c_BLANK_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == '0) begin
            state_d = ST_SHOW;
            cnt_d   = c_SHOW_LOAD;
            idx_d   = idx_q + 3'd1;
            w_wrap  = (idx_q == 3'd7);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end
      endcase
    end

    // A word accepted on the wrap edge cannot collide with a transfer:
    // acceptance requires the pending register to be empty.
    if (w_wrap && pend_full_q) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end

    if (w_accept) begin
      if (state_q == ST_IDLE) begin
        disp_data_d = bus.data_in;
        disp_dp_d   = bus.dp_in;
      end else begin
        pend_data_d = bus.data_in;
        pend_dp_d   = bus.dp_in;
        pend_full_d = 1'b1;
      end
    end
  end

  assign w_nibble = disp_data_d[4*idx_d +: 4];

  hex7seg u_hex7seg (
    .nibble_i (w_nibble),
    .seg_o    (w_seg7)
  );

`ifdef LZ_BLANK_EN
  assign w_lz_blank = (idx_d > msd_index(disp_data_d));
`else
  assign w_lz_blank = 1'b0;
`endif

  // Outputs are computed from next-state so they land on the same edge.
  always_comb begin
    sel_d        = sel_q;
    dec_d        = c_DEC_OFF;
    seg_d        = c_SEG_DARK;
    frame_done_d = w_wrap;
    ready_d      = ~pend_full_d;

    if (state_d == ST_SHOW) begin
      sel_d = idx_d;
      dec_d = c_DEC_ON;
      seg_d = {~disp_dp_d[idx_d], (w_lz_blank ? c_SEG_BLANK : w_seg7)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      disp_data_q  <= 32'd0;
      disp_dp_q    <= 8'd0;
      pend_data_q  <= 32'd0;
      pend_dp_q    <= 8'd0;
      pend_full_q  <= 1'b0;
      ready_q      <= 1'b1;
      sel_q        <= 3'd0;
      dec_q        <= c_DEC_OFF;
      seg_q        <= c_SEG_DARK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      ready_q      <= ready_d;
      sel_q        <= sel_d;
      dec_q        <= dec_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.sel_a      = sel_q[2];
  assign bus.sel_b      = sel_q[1];
  assign bus.sel_c      = sel_q[0];
  assign bus.dec_e1     = dec_q.e1;
  assign bus.dec_e2     = dec_q.e2;
  assign bus.dec_e3     = dec_q.e3;
  assign bus.seg_n      = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// | Module : tb_seg_scan_ctrl                                               |
// | Scoreboard bench for seg_scan_ctrl (SCAN_DIV=4, BLANK_CYC=2).           |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int c_SCAN  = 4;
  localparam int c_BLANK = 2;
  localparam int c_FRAME = 8 * (c_SCAN + c_BLANK);

  logic clk = 1'b0;
  logic rst_n;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.SCAN_DIV(c_SCAN), .BLANK_CYC(c_BLANK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [10:0] sb_q [$];
  logic        r_skip = 1'b1;
  wire  [2:0]  w_sel = {bus.sel_a, bus.sel_b, bus.sel_c};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic logic [7:0] exp_seg(input logic [31:0] d, input logic [7:0] dp, input int i);
    logic [7:0] s;
    case (d[4*i +: 4])
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
`ifdef LZ_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int j = 0; j < 8; j++) if (d[4*j +: 4] != 4'd0) msd = j;
      if (i > msd) s = 8'hFF;
    end
`endif
    s[7] = ~dp[i];
    return s;
  endfunction

  task automatic push_frame(input logic [31:0] d, input logic [7:0] dp, input int ndig);
    for (int i = 0; i < ndig; i++) sb_q.push_back({3'(i), exp_seg(d, dp, i)});
  endtask

  // Monitor: pops one expectation per lit digit, checks lit/dark lengths and frame period.
  logic r_prev_e1 = 1'b0;
  logic r_mid     = 1'b0;
  logic r_have_fd = 1'b0;
  int   lit_len = 0, dark_len = 0, fd_gap = 0;

  always @(negedge clk) begin
    logic [10:0] e;
    if (r_skip) begin
      r_mid     = 1'b0;
      r_have_fd = 1'b0;
    end
    if (bus.dec_e1 && !r_prev_e1) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("digit_sel", 32'(w_sel), 32'(e[10:8]));
        check("digit_seg", 32'(bus.seg_n), 32'(e[7:0]));
      end
      if (r_mid && !r_skip) check("dark_len", dark_len, c_BLANK);
      lit_len = 0;
      r_mid   = 1'b0;
    end
    if (!bus.dec_e1 && r_prev_e1) begin
      if (!r_skip) check("lit_len", lit_len, c_SCAN);
      r_mid    = !r_skip;
      dark_len = 0;
    end
    if (bus.dec_e1) lit_len++;
    else dark_len++;
    if (bus.frame_done) begin
      check("fd_digit0", {28'd0, bus.dec_e1, w_sel}, 32'h8);
      if (r_have_fd) check("frame_period", fd_gap, c_FRAME);
      r_have_fd = !r_skip;
      fd_gap    = 0;
    end
    fd_gap++;
    r_prev_e1 = bus.dec_e1;
  end

  task automatic load_word(input logic [31:0] d, input logic [7:0] dp);
    @(posedge clk); #1;
    bus.data_in    = d;
    bus.dp_in      = dp;
    bus.load_valid = 1'b1;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_lit(input logic [2:0] d);
    logic prev;
    logic found;
    prev  = bus.dec_e1;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (bus.dec_e1 && !prev && w_sel == d) found = 1'b1;
      prev = bus.dec_e1;
    end
    if (!found) check("wait_lit_timeout", 32'(found), 32'd1);
  endtask

  task automatic wait_fd();
    logic found;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (bus.frame_done) found = 1'b1;
    end
    if (!found) check("wait_fd_timeout", 32'(found), 32'd1);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_e"}, {29'd0, bus.dec_e1, bus.dec_e2, bus.dec_e3}, 32'h3);
    check({tag, "_seg"}, 32'(bus.seg_n), 32'hFF);
  endtask

  localparam logic [31:0] c_W1 = 32'h0BADF00D;
  localparam logic [31:0] c_W2 = 32'hCAFE1234;
  localparam logic [31:0] c_W3 = 32'h00000A05;

  initial begin
    logic ok;
    rst_n          = 1'b0;
    bus.scan_en    = 1'b0;
    bus.load_valid = 1'b0;
    bus.data_in    = 32'd0;
    bus.dp_in      = 8'd0;
    repeat (2) @(negedge clk);
    check_dark("rst");
    check("rst_sel", 32'(w_sel), 32'd0);
    check("rst_ready", 32'(bus.load_ready), 32'd1);
    check("rst_fd", 32'(bus.frame_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    load_word(32'h12345678, 8'h00);
    @(negedge clk);
    check("idle_load_ready", 32'(bus.load_ready), 32'd1);

    push_frame(32'h12345678, 8'h00, 8);
    push_frame(32'hAAAAAAAA, 8'h00, 8);
    push_frame(c_W1, 8'h0F, 8);
    push_frame(c_W2, 8'h50, 8);
    push_frame(c_W2, 8'h50, 8);
    push_frame(c_W3, 8'h80, 6);
    r_skip = 1'b0;

    @(posedge clk); #1;
    bus.scan_en = 1'b1;
    @(negedge clk);
    check("start_still_dark", 32'(bus.dec_e1), 32'd0);
    @(negedge clk);
    check("start_digit0", {28'd0, bus.dec_e1, w_sel}, 32'h8);
    check("start_seg", 32'(bus.seg_n), 32'h80);

    // Load while digit 3 of frame 0 is lit
    wait_lit(3'd3);
    load_word(32'hAAAAAAAA, 8'h00);
    @(negedge clk);
    check("scan_load_ready_low", 32'(bus.load_ready), 32'd0);
    wait_lit(3'd7);
    check("ready_held_to_wrap", 32'(bus.load_ready), 32'd0);
    wait_fd();
    check("ready_up_at_wrap", 32'(bus.load_ready), 32'd1);

    // Back-to-back loads in frame 1
    wait_lit(3'd2);
    load_word(c_W1, 8'h0F);
    wait_lit(3'd4);
    check("b2b_wait", 32'(bus.load_ready), 32'd0);
    @(posedge clk); #1;
    bus.data_in    = c_W2;
    bus.dp_in      = 8'h50;
    bus.load_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (bus.load_ready) ok = 1'b1;
    end
    check("b2b_ready_seen", 32'(ok), 32'd1);
    check("b2b_ready_on_wrap", 32'(bus.frame_done), 32'd1);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_pending", 32'(bus.load_ready), 32'd0);

    // Word presented exactly on the wrap edge between frames 3 and 4
    wait_fd();
    check("f3_ready", 32'(bus.load_ready), 32'd1);
    wait_lit(3'd7);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (!bus.dec_e1) ok = 1'b1;
    end
    check("d7_dark_seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.data_in    = c_W3;
    bus.dp_in      = 8'h80;
    bus.load_valid = 1'b1;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    @(negedge clk);
    check("wrap_edge_fd", 32'(bus.frame_done), 32'd1);
    check("wrap_edge_pending", 32'(bus.load_ready), 32'd0);
    wait_fd();
    check("f5_ready", 32'(bus.load_ready), 32'd1);

    // Stop during digit 5 of frame 5
    wait_lit(3'd5);
    r_skip = 1'b1;
    @(posedge clk); #1;
    bus.scan_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_dark("stop");
    check("stop_sel_hold", 32'(w_sel), 32'd5);
    repeat (3) @(negedge clk);
    check_dark("idle");

    // Restart from digit 0, then reset asynchronously with a word pending
    r_skip = 1'b0;
    push_frame(c_W3, 8'h80, 3);
    @(posedge clk); #1;
    bus.scan_en = 1'b1;
    @(negedge clk);
    check("restart_dark", 32'(bus.dec_e1), 32'd0);
    @(negedge clk);
    check("restart_digit0", {28'd0, bus.dec_e1, w_sel}, 32'h8);
    wait_lit(3'd2);
    load_word(32'h11111111, 8'hFF);
    @(negedge clk);
    check("pre_rst_pending", 32'(bus.load_ready), 32'd0);
    r_skip = 1'b1;
    @(negedge clk); #2;
    rst_n       = 1'b0;
    bus.scan_en = 1'b0;
    #1;
    check_dark("async_rst");
    check("async_rst_sel", 32'(w_sel), 32'd0);
    check("async_rst_ready", 32'(bus.load_ready), 32'd1);
    check("async_rst_fd", 32'(bus.frame_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both buffers must be cleared: two frames of zeros
    r_skip = 1'b0;
    push_frame(32'd0, 8'd0, 8);
    push_frame(32'd0, 8'd0, 8);
    @(posedge clk); #1;
    bus.scan_en = 1'b1;
    wait_lit(3'd7);
    wait_lit(3'd7);
    r_skip = 1'b1;
    @(posedge clk); #1;
    bus.scan_en = 1'b0;
    repeat (3) @(negedge clk);
    check_dark("final");
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
